// File: rtl/rs_syndrome_5.sv
// rs_syndrome_5: computes the two Reed-Solomon syndromes S1 = r(alpha) and
// S2 = r(alpha^2) over GF(2^5) (x^5+x^2+1) for a stream of received symbols,
// highest-degree coefficient first, using Horner accumulation.
//
// Handshake: there is no back-pressure. A symbol is accepted on any rising
// edge where sym_valid_i=1; sof_i is only meaningful on such an edge.
// syn_valid_o and abort_o are single-cycle strobes; syn1_o/syn2_o/err_o hold
// their values between syn_valid_o strobes.
module rs_syndrome_5 #(
   parameter int N_SYM = 31
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] sym_i,
   input  logic       sym_valid_i,
   input  logic       sof_i,
   output logic [4:0] syn1_o,
   output logic [4:0] syn2_o,
   output logic       syn_valid_o,
   output logic       err_o,
   output logic       abort_o
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] ACCUM = 1'b1;

   // Count value held just before the final symbol of a codeword arrives.
   localparam logic [4:0] LAST_CNT = 5'(N_SYM - 1);

   logic [0:0] state;
   logic [4:0] acc1;
   logic [4:0] acc2;
   logic [4:0] cnt;
   logic [4:0] nxt1;
   logic [4:0] nxt2;

   // Constant multiply by alpha: shift, then fold x^5 back as x^2+1.
   function automatic logic [4:0] mul_a(input logic [4:0] a);
      return {a[3:0], 1'b0} ^ (a[4] ? 5'h05 : 5'h00);
   endfunction

   // Constant multiply by alpha^2: two cascaded alpha steps.
   function automatic logic [4:0] mul_a2(input logic [4:0] a);
      return mul_a(mul_a(a));
   endfunction

   // Horner step for both syndromes with the incoming symbol.
   always_comb begin
      nxt1 = mul_a(acc1) ^ sym_i;
      nxt2 = mul_a2(acc2) ^ sym_i;
   end

   // Codeword FSM, accumulators and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         acc1        <= 5'h00;
         acc2        <= 5'h00;
         cnt         <= 5'h00;
         syn1_o      <= 5'h00;
         syn2_o      <= 5'h00;
         err_o       <= 1'b0;
         syn_valid_o <= 1'b0;
         abort_o     <= 1'b0;
      end else begin
         syn_valid_o <= 1'b0;
         abort_o     <= 1'b0;
         case (state)
            IDLE: begin
               // Symbols without sof_i are dropped silently while idle.
               if (sym_valid_i && sof_i) begin
                  acc1  <= sym_i;
                  acc2  <= sym_i;
                  cnt   <= 5'd1;
                  state <= ACCUM;
               end
            end
            ACCUM: begin
               if (sym_valid_i) begin
                  if (sof_i) begin
                     // Early restart: drop the open codeword, start over here.
                     abort_o <= 1'b1;
                     acc1    <= sym_i;
                     acc2    <= sym_i;
                     cnt     <= 5'd1;
                  end else begin
                     acc1 <= nxt1;
                     acc2 <= nxt2;
                     cnt  <= cnt + 5'd1;
                     if (cnt == LAST_CNT) begin
                        syn1_o      <= nxt1;
                        syn2_o      <= nxt2;
                        err_o       <= |{nxt1, nxt2};
                        syn_valid_o <= 1'b1;
                        state       <= IDLE;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rs_syndrome_5.sv
// tb_rs_syndrome_5: directed codewords with hand-computed syndromes; a
// negedge monitor pops the expected queue on every syn_valid_o and checks
// that outputs hold in between.
module tb_rs_syndrome_5;

   localparam int N = 31;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] sym_i = 5'h00;
   logic       sym_valid_i = 1'b0;
   logic       sof_i = 1'b0;
   logic [4:0] syn1_o;
   logic [4:0] syn2_o;
   logic       syn_valid_o;
   logic       err_o;
   logic       abort_o;

   rs_syndrome_5 #(.N_SYM(N)) dut (
      .clk         (clk),
      .rst         (rst),
      .sym_i       (sym_i),
      .sym_valid_i (sym_valid_i),
      .sof_i       (sof_i),
      .syn1_o      (syn1_o),
      .syn2_o      (syn2_o),
      .syn_valid_o (syn_valid_o),
      .err_o       (err_o),
      .abort_o     (abort_o)
   );

   // Clock and cycle counter.
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard state: expected {syn1, syn2, err} per codeword.
   logic [10:0] exp_q[$];
   int          strobe_cyc[$];
   logic [10:0] hold = 11'h000;
   int          total = 0;
   int          bad = 0;
   int          abort_seen = 0;
   int          abort_exp = 0;
   logic [4:0]  cw [0:N-1];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every strobe pops one expectation; otherwise outputs must hold.
   always @(negedge clk) begin
      if (rst) begin
         hold = 11'h000;
         chk("outputs_in_reset", {syn1_o, syn2_o, err_o, syn_valid_o, abort_o}, 32'h0);
      end else begin
         if (abort_o) abort_seen++;
         if (syn_valid_o) begin
            strobe_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_strobe: got syn_valid_o=1 expected no strobe (t=%0t)", $time);
            end else begin
               hold = exp_q.pop_front();
               chk("syndrome", {syn1_o, syn2_o, err_o}, hold);
            end
         end else begin
            chk("hold", {syn1_o, syn2_o, err_o}, hold);
         end
      end
   end

   // Drive one cycle of inputs, return just after the active edge.
   task automatic drive(input logic v, input logic s, input logic [4:0] d);
      sym_valid_i = v;
      sof_i       = s;
      sym_i       = d;
      @(posedge clk);
      #1;
   endtask

   // All-zero codeword with up to two non-zero positions (index 0 sent first).
   task automatic build(input int p1, input logic [4:0] v1, input int p2, input logic [4:0] v2);
      for (int i = 0; i < N; i++) cw[i] = 5'h00;
      cw[p1] = v1;
      cw[p2] = v2;
   endtask

   // Send cw[], optionally with random stall cycles; checks 1-cycle latency.
   task automatic send_cw(input logic [10:0] exp, input bit gaps);
      exp_q.push_back(exp);
      for (int i = 0; i < N; i++) begin
         if (gaps && i > 0) begin
            repeat ($urandom_range(0, 2)) drive(1'b0, 1'b0, 5'($urandom_range(0, 31)));
         end
         drive(1'b1, i == 0, cw[i]);
      end
      chk("latency", {31'h0, syn_valid_o}, 32'h1);
      sym_valid_i = 1'b0;
      sof_i       = 1'b0;
   endtask

   initial begin
      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_syn1", {27'h0, syn1_o}, 32'h0);
      chk("rst_syn2", {27'h0, syn2_o}, 32'h0);
      chk("rst_err", {31'h0, err_o}, 32'h0);
      chk("rst_valid", {31'h0, syn_valid_o}, 32'h0);
      chk("rst_abort", {31'h0, abort_o}, 32'h0);
      #2 rst = 1'b0;

      // Symbols without sof while idle are ignored.
      drive(1'b1, 1'b0, 5'h1f);
      drive(1'b1, 1'b0, 5'h07);
      drive(1'b0, 1'b0, 5'h00);

      // All-zero codeword.
      build(0, 5'h00, 0, 5'h00);
      send_cw({5'h00, 5'h00, 1'b0}, 1'b0);
      drive(1'b0, 1'b0, 5'h00);

      // Back-to-back: last=01 then second-to-last=01, zero gap.
      strobe_cyc.delete();
      build(30, 5'h01, 30, 5'h01);
      send_cw({5'h01, 5'h01, 1'b1}, 1'b0);
      build(29, 5'h01, 29, 5'h01);
      send_cw({5'h02, 5'h04, 1'b1}, 1'b0);
      @(negedge clk);
      #1;
      chk("b2b_strobes", strobe_cyc.size(), 32'd2);
      if (strobe_cyc.size() == 2) chk("b2b_spacing", strobe_cyc[1] - strobe_cyc[0], 32'd31);

      // Same second-to-last pattern with random stalls.
      send_cw({5'h02, 5'h04, 1'b1}, 1'b1);
      drive(1'b0, 1'b0, 5'h00);

      // Restart at symbol 10: abort, then first=01 gives alpha^30 / alpha^29.
      for (int k = 0; k < 9; k++) drive(1'b1, k == 0, 5'($urandom_range(1, 31)));
      abort_exp++;
      build(0, 5'h01, 0, 5'h01);
      send_cw({5'h12, 5'h09, 1'b1}, 1'b0);
      drive(1'b0, 1'b0, 5'h00);

      // Reset at symbol 20: outputs clear immediately, no strobe.
      build(28, 5'h01, 28, 5'h01);
      for (int i = 0; i < 19; i++) drive(1'b1, i == 0, cw[i]);
      sym_valid_i = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst_now_syn", {22'h0, syn1_o, syn2_o}, 32'h0);
      chk("rst_now_err", {31'h0, err_o}, 32'h0);
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;

      // Two non-zero symbols: 01 at index 29, 03 at index 30.
      build(29, 5'h01, 30, 5'h03);
      send_cw({5'h01, 5'h07, 1'b1}, 1'b0);
      // Third-from-last = 01: alpha^2 / alpha^4.
      build(28, 5'h01, 28, 5'h01);
      send_cw({5'h04, 5'h10, 1'b1}, 1'b1);

      repeat (4) drive(1'b0, 1'b0, 5'h00);
      chk("queue_drained", exp_q.size(), 32'd0);
      chk("abort_count", abort_seen, abort_exp);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global bound so the run always terminates.
   initial begin
      #200000;
      $display("FAIL timeout: got no completion expected finish before 200000");
      $fatal(1);
   end

endmodule

// File: doc/rs_syndrome_5.md
RS_SYNDROME_5 -- requirements
Module: rs_syndrome_5

Interface
REQ-001 The block SHALL have parameter N_SYM, default 31, meaning codeword length in 5-bit symbols; legal range 3..31.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have port sym_i  input  5  received GF(2^5) symbol, highest-degree coefficient first.
REQ-005 The block SHALL have port sym_valid_i  input  1  sym_i carries a symbol this cycle.
REQ-006 The block SHALL have port sof_i  input  1  qualified by sym_valid_i; marks the first symbol of a codeword.
REQ-007 The block SHALL have port syn1_o  output  5  syndrome S1 = r(alpha).
REQ-008 The block SHALL have port syn2_o  output  5  syndrome S2 = r(alpha^2).
REQ-009 The block SHALL have port syn_valid_o  output  1  one-cycle strobe: syn1_o, syn2_o and err_o are new.
REQ-010 The block SHALL have port err_o  output  1  at least one of syn1_o or syn2_o is non-zero.
REQ-011 The block SHALL have port abort_o  output  1  one-cycle strobe: a codeword was discarded because sof_i restarted it before completion.

Function
REQ-012 Field arithmetic SHALL be GF(2^5) with primitive polynomial x^5+x^2+1 (alpha = 5'h02, alpha^5 = 5'h05); addition is bitwise XOR.
REQ-013 Multiplication by alpha and by alpha^2 SHALL be fixed combinational constant multipliers; no general multiplier is used.
REQ-014 The FSM SHALL have two states: IDLE (no codeword open) and ACCUM (codeword open).
REQ-015 In IDLE, sym_valid_i=1 with sof_i=1 SHALL load acc1 = sym_i and acc2 = sym_i, set the symbol count to 1 and enter ACCUM.
REQ-016 In IDLE, sym_valid_i=1 with sof_i=0 SHALL be ignored without any flag.
REQ-017 In ACCUM, sym_valid_i=1 with sof_i=0 SHALL update acc1 = acc1*alpha XOR sym_i, acc2 = acc2*alpha^2 XOR sym_i and increment the count.
REQ-018 In ACCUM, sym_valid_i=0 SHALL hold all state (stall); there is no timeout.
REQ-019 When the count reaches N_SYM on an accepted symbol, the cycle after that symbol SHALL drive syn1_o and syn2_o with the final values, pulse syn_valid_o for exactly 1 cycle, and set err_o.
REQ-020 In the same edge as REQ-019, the FSM SHALL return to IDLE.
REQ-021 Latency SHALL be 1 clock from the last symbol edge to syn_valid_o.
REQ-022 A sof_i on the cycle directly after the last symbol SHALL be accepted; back-to-back codewords run with zero gap.
REQ-023 In ACCUM with count < N_SYM, sym_valid_i=1 with sof_i=1 SHALL pulse abort_o for 1 cycle, produce no syn_valid_o, and restart accumulation from that symbol per REQ-015.
REQ-024 syn1_o, syn2_o and err_o SHALL hold their last values until the next syn_valid_o.
REQ-025 The symbol count SHALL be 5 bits and SHALL never wrap; it is cleared on every start.

Reset
REQ-026 While rst=1, all outputs SHALL be 0, the accumulators and count SHALL be 0, and the FSM SHALL be in IDLE, independent of clk.
REQ-027 Reset asserted mid-codeword SHALL discard the partial codeword with no syn_valid_o and no abort_o.
REQ-028 After reset deasserts, the first accepted sof_i SHALL start a codeword normally.

Verification
REQ-029 All-zero codeword, N_SYM=31, continuous valid -> syn_valid_o pulses 1 cycle after symbol 31; syn1_o=5'h00, syn2_o=5'h00, err_o=0.
REQ-030 All-zero codeword except the last symbol = 5'h01 -> syn1_o=5'h01, syn2_o=5'h01, err_o=1.
REQ-031 All-zero codeword except the second-to-last symbol = 5'h01 -> syn1_o=5'h02, syn2_o=5'h04; insert random sym_valid_i gaps -> identical results and no extra strobes.
REQ-032 sof_i again at symbol 10 -> abort_o pulses once; the following 31 symbols produce exactly one syn_valid_o.
REQ-033 Two codewords back-to-back with zero gap -> two syn_valid_o strobes exactly 31 cycles apart; each carries correct syndromes.
REQ-034 rst pulsed at symbol 20 -> outputs are 0 at once; no strobe; the next codeword is correct.
